shift_seq: RTL and testbench
============================

# shift_seq

Iterative 16-bit shift unit for the multicycle datapath. It complements the combinational single-step left shifter: it performs logical-right, arithmetic-right, logical-left and rotate-right shifts by a 4-bit amount, one bit per clock. Control issues a `start` pulse, and the unit returns a one-cycle `done` with the result held on `y`. It sits beside the ALU and is sequenced by the multicycle controller.

## Interface
- `WIDTH`, 16, data width
- `AMT_W`, 4, shift-amount width (log2 WIDTH)
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  request; sampled only when `busy`=0
- `op`  in  2  operation: 00 SRL, 01 SRA, 10 SLL, 11 ROR
- `a`  in  WIDTH  operand, latched on accepted start
- `shamt`  in  AMT_W  shift amount 0..15, latched on accepted start
- `busy`  out  1  high while shifting (state SHIFT)
- `done`  out  1  one-cycle pulse, `y` valid
- `y`  out  WIDTH  result; holds until next accepted start

## Operation
- States:
  - IDLE: waiting for a request.
  - SHIFT: one 1-bit step per cycle.
  - DONE: result presented for one cycle.
- Registers: `acc`[WIDTH], `cnt`[AMT_W], `op_q`[2], state. `y` = `acc` (registered, no combinational path from `a`).
- Accepted start, from IDLE or DONE (`busy`=0):
  - `acc`<=`a`, `cnt`<=`shamt`, `op_q`<=`op`.
  - Next state is DONE if `shamt`==0, otherwise SHIFT.
- SHIFT, each edge:
  - `acc`<=step(`acc`,`op_q`), `cnt`<=`cnt`-1.
  - If `cnt`==1, next state is DONE.
- DONE: `done`=1 for this cycle. Next state is IDLE unless a new start is accepted in that cycle (back-to-back).
- One-bit step:
  - SRL: {0, acc[15:1]}
  - SRA: {acc[15], acc[15:1]}
  - SLL: {acc[14:0], 0}
  - ROR: {acc[0], acc[15:1]}
- `start` while `busy`=1 is ignored. Inputs are not re-sampled and the operation in flight is unaffected.
- Inputs `op`, `a` and `shamt` may change freely after the accepting edge.
- `shamt` is never reduced modulo anything. 15 is the maximum, so there is no wrap case. `cnt` never underflows.

## Timing
- Reset values (async assert, synchronous-clean deassert): state IDLE, `acc`=0, `cnt`=0, `op_q`=0, `busy`=0, `done`=0, `y`=0.
- Let edge k be the edge that accepts start.
  - `shamt`=s>0: `busy`=1 after edges k..k+s-1. `done`=1 in the cycle after edge k+s. Latency is s+1 cycles.
  - `shamt`=0: `done`=1 in the cycle after edge k. Latency is 1 cycle, and `busy` never asserts.
- `done` is exactly one cycle wide. `busy` and `done` are never both high.
- Reset mid-SHIFT aborts immediately to reset values, and no `done` is produced. The first start after reset deassertion is accepted normally.
- Start accepted in a DONE cycle: `done` drops next cycle and the new operation timing restarts from that edge.
- Throughput: one operation per s+1 cycles.

## Structure
- Package `shift_pkg`:
  - Op encodings `OP_SRL`/`OP_SRA`/`OP_SLL`/`OP_ROR`.
  - State enum `IDLE`/`SHIFT`/`DONE`.
  - `WIDTH`/`AMT_W` defaults.
- Sub-module `shift1_step`: combinational, inputs (`acc`, `op`), output the one-bit-shifted word. It is the single-step counterpart to the existing left-shift-by-one block, and it is verified standalone as well.
- Top: FSM plus `acc`/`cnt` registers plus one `shift1_step` instance.

## Test plan
- Reset, then SRL of `a`=16'habcd, `shamt`=4 -> `busy` high 4 cycles, `done` pulses once, `y`=16'h0abc.
- SRA of `a`=16'h8000, `shamt`=15 -> `y`=16'hffff after 16 cycles. SLL of 16'hffff, `shamt`=1 -> `y`=16'hfffe.
- ROR of 16'habcd, `shamt`=4 -> `y`=16'hdabc. SRL of 16'h1234, `shamt`=0 -> `done` one cycle after start, `y`=16'h1234, `busy` never high.
- `start` re-pulsed with `a`=16'h0000 mid-way through SRL 16'hffff by 8 -> ignored, `y`=16'h00ff, single `done`.
- Assert `rst` during SHIFT -> `y`=0, `busy`=0, `done`=0 with no pulse. A fresh SLL of 16'h0001 by 3 -> `y`=16'h0008.
- Start asserted in the DONE cycle (SRL 16'hf000 by 4) -> result 16'h0f00 with correct latency, and no missed or duplicated `done`.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared constants and types for the iterative shift unit.
// Operation encodings, FSM states and data/amount widths.
package shift_pkg;

    localparam int WIDTH = 16;
    localparam int AMT_W = 4;

    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_SLL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift1_step.sv
// Combinational one-bit step of the iterative shifter.
// Right-going ops differ only in the bit that enters at the top.
module shift1_step
    import shift_pkg::*;
(
    input  logic [WIDTH-1:0] acc,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = acc;
        case (op)
            OP_SRL:  y = {1'b0, acc[WIDTH-1:1]};
            OP_SRA:  y = {acc[WIDTH-1], acc[WIDTH-1:1]};
            OP_SLL:  y = {acc[WIDTH-2:0], 1'b0};
            OP_ROR:  y = {acc[0], acc[WIDTH-1:1]};
            default: y = acc;
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// Iterative 16-bit shifter: SRL/SRA/SLL/ROR by 0..15, one bit per clock.
// Handshake: start is accepted on any edge where busy=0; done pulses one cycle with y valid.
module shift_seq
    import shift_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output state_t           state
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] acc;
    logic [AMT_W-1:0] cnt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] step;
    logic             accept;

    shift1_step u_step (
        .acc (acc),
        .op  (op_q),
        .y   (step)
    );

    // DONE is not busy, so a new request can chain directly off a finished one.
    assign accept = start && (state_q != SHIFT);

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start)
                    state_d = (shamt == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == AMT_W'(1))
                    state_d = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start)
                    state_d = (shamt == '0) ? DONE : SHIFT;
                else
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                acc  <= a;
                cnt  <= shamt;
                op_q <= op;
            end else if (state_q == SHIFT) begin
                acc <= step;
                cnt <= cnt - AMT_W'(1);
            end
        end
    end

    assign y     = acc;
    assign state = state_q;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed literal cases plus random traffic,
// checked every cycle against an arithmetic model and a result queue.
module tb_shift_seq;
    import shift_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a;
    logic [3:0]  shamt;
    logic        busy;
    logic        done;
    logic [15:0] y;
    state_t      dut_state;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];

    // Model: operation described as "j of s bit-steps applied so far".
    bit          m_active;
    bit          m_busy;
    bit          m_done;
    logic [15:0] m_a;
    logic [1:0]  m_op;
    int          m_s;
    int          m_j;

    shift_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .shamt (shamt),
        .busy  (busy),
        .done  (done),
        .y     (y),
        .state (dut_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference arithmetic ----------------
    function automatic logic [15:0] ref_shift(input logic [15:0] v, input logic [1:0] o, input int n);
        logic [31:0] dbl;
        logic [15:0] r;
        case (o)
            2'b00: r = v >> n;
            2'b01: r = 16'($signed(v) >>> n);
            2'b10: r = v << n;
            default: begin
                dbl = {v, v};
                r   = 16'(dbl >> n);
            end
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model update ----------------
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0; m_busy = 0; m_done = 0;
            m_a = '0; m_op = '0; m_s = 0; m_j = 0;
            exp_q.delete();
        end else begin
            if (start && !m_busy) begin
                m_a = a; m_op = op; m_s = int'(shamt); m_j = 0; m_active = 1;
                exp_q.push_back(ref_shift(a, op, int'(shamt)));
            end else if (m_busy) begin
                m_j++;
            end else begin
                m_active = 0;
            end
            m_busy = m_active && (m_j < m_s);
            m_done = m_active && (m_j == m_s);
        end
    end

    // ---------------- per-cycle compare + scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", {15'b0, busy}, {15'b0, m_busy});
            chk("done", {15'b0, done}, {15'b0, m_done});
            chk("y", y, ref_shift(m_a, m_op, m_j));
            chk("busy_and_done", {15'b0, busy & done}, 16'h0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_done", 16'h1, 16'h0);
                end else begin
                    chk("sb_result", y, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge with the DUT idle or in DONE; returns at the negedge of the DONE cycle.
    task automatic do_op(input string nm, input logic [1:0] o, input logic [15:0] av,
                         input logic [3:0] s, input logic [15:0] exp_y);
        int lat;
        bit seen;
        int busy_cycles;
        op = o; a = av; shamt = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom_range(0, 3)); a = 16'($urandom); shamt = 4'($urandom_range(0, 15));
        lat = 1; seen = 0; busy_cycles = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done) seen = 1;
            else begin
                if (busy) busy_cycles++;
                @(negedge clk);
                lat++;
            end
        end
        chk({nm, "_seen"}, {15'b0, seen}, 16'h1);
        chk({nm, "_y"}, y, exp_y);
        chk({nm, "_latency"}, 16'(lat), 16'(int'(s) + 1));
        chk({nm, "_busy_cycles"}, 16'(busy_cycles), 16'(s));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int dones;
        rst = 1'b1; start = 1'b0; op = '0; a = '0; shamt = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_y", y, 16'h0);
        chk("reset_busy", {15'b0, busy}, 16'h0);
        chk("reset_done", {15'b0, done}, 16'h0);
        rst = 1'b0;
        idle(2);

        do_op("srl_abcd_4", OP_SRL, 16'habcd, 4'd4, 16'h0abc);
        idle(2);
        do_op("sra_8000_15", OP_SRA, 16'h8000, 4'd15, 16'hffff);
        idle(1);
        do_op("sll_ffff_1", OP_SLL, 16'hffff, 4'd1, 16'hfffe);
        idle(1);
        do_op("ror_abcd_4", OP_ROR, 16'habcd, 4'd4, 16'hdabc);
        idle(1);
        do_op("srl_1234_0", OP_SRL, 16'h1234, 4'd0, 16'h1234);
        idle(2);

        // Ignored re-start mid-operation.
        op = OP_SRL; a = 16'hffff; shamt = 4'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idle(3);
        a = 16'h0000; shamt = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) begin
                dones++;
                chk("ignored_start_y", y, 16'h00ff);
            end
            @(negedge clk);
        end
        chk("ignored_start_done_count", 16'(dones), 16'h1);

        // Reset during SHIFT.
        op = OP_SRL; a = 16'hffff; shamt = 4'd12; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idle(3);
        #2 rst = 1'b1;
        #1;
        chk("midreset_y", y, 16'h0);
        chk("midreset_busy", {15'b0, busy}, 16'h0);
        chk("midreset_done", {15'b0, done}, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        chk("midreset_no_done", 16'(dones), 16'h0);
        do_op("sll_0001_3", OP_SLL, 16'h0001, 4'd3, 16'h0008);

        // Back-to-back: next start issued in the DONE cycle.
        idle(1);
        do_op("b2b_first", OP_SLL, 16'h00f0, 4'd2, 16'h03c0);
        do_op("b2b_srl_f000_4", OP_SRL, 16'hf000, 4'd4, 16'h0f00);
        do_op("b2b_zero", OP_ROR, 16'h1357, 4'd0, 16'h1357);
        idle(2);

        // Random traffic, including starts while busy and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 3) == 0);
            op    = 2'($urandom_range(0, 3));
            a     = 16'($urandom);
            shamt = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        start = 1'b0;
        idle(20);
        chk("final_queue_empty", 16'(exp_q.size()), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
